// File: rtl/rn_seq_pkg.sv
// Shared types and helpers for the bank RN release sequencer.
package rn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    GAP     = 2'd2,
    RELEASE = 2'd3
  } state_e;

  localparam int MAX_BANKS       = 32;
  localparam int MIN_BANKS       = 1;
  localparam int MIN_HOLD_CYCLES = 1;
  localparam int MIN_GAP_CYCLES  = 1;

  // Isolates the lowest set bit as a one-hot vector (zero in, zero out).
  function automatic logic [MAX_BANKS-1:0] lowest_set(input logic [MAX_BANKS-1:0] v);
    return v & (~v + MAX_BANKS'(1));
  endfunction

endpackage

// File: rtl/rn_seq_timer.sv
// Small up-counter with sync load-to-1 and equality hit against HOLD or GAP limit.
module rn_seq_timer #(
  parameter int HOLD_LIM = 4,
  parameter int GAP_LIM  = 2,
  parameter int CNT_W    = 3
) (
  input  logic clk,
  input  logic load,
  input  logic en,
  input  logic sel_gap,
  output logic hit
);

  localparam logic [CNT_W-1:0] HOLD_L = CNT_W'(HOLD_LIM);
  localparam logic [CNT_W-1:0] GAP_L  = CNT_W'(GAP_LIM);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (load)
      cnt <= CNT_W'(1);
    else if (en && !hit)
      cnt <= cnt + CNT_W'(1);
  end

  assign hit = (cnt == (sel_gap ? GAP_L : HOLD_L));

endmodule

// File: rtl/rn_bank_release_seq.sv
// Sequences active-low bank resets: hold low, then release banks one by one
// in ascending order with a fixed gap between releases.
module rn_bank_release_seq
  import rn_seq_pkg::*;
#(
  parameter int N_BANKS     = 4,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = $clog2((HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES) + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ,
  input  logic [N_BANKS-1:0] MASK,
  output logic [N_BANKS-1:0] RN_OUT,
  output logic               BUSY,
  output logic               DONE,
  output logic               REQ_ERR
);

  if (N_BANKS < MIN_BANKS || N_BANKS > MAX_BANKS) begin : g_bad_banks
    $error("rn_bank_release_seq: N_BANKS out of range");
  end
  if (HOLD_CYCLES < MIN_HOLD_CYCLES) begin : g_bad_hold
    $error("rn_bank_release_seq: HOLD_CYCLES must be >= 1");
  end
  if (GAP_CYCLES < MIN_GAP_CYCLES) begin : g_bad_gap
    $error("rn_bank_release_seq: GAP_CYCLES must be >= 1");
  end

  state_e             state;
  logic [N_BANKS-1:0] pend;
  logic [N_BANKS-1:0] rel_onehot;
  logic [N_BANKS-1:0] pend_next;
  logic               active;
  logic               accept;
  logic               tmr_load;
  logic               tmr_hit;

  assign active     = (state == HOLD) || (state == GAP);
  assign accept     = (state == IDLE) && REQ && (|MASK);
  assign rel_onehot = N_BANKS'(lowest_set(MAX_BANKS'(pend)));
  assign pend_next  = pend & ~rel_onehot;
  // Timer restarts on reset, on an accepted request and after every release.
  assign tmr_load   = RST || accept || (active && tmr_hit);

  rn_seq_timer #(
    .HOLD_LIM (HOLD_CYCLES),
    .GAP_LIM  (GAP_CYCLES),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk     (CLK),
    .load    (tmr_load),
    .en      (active),
    .sel_gap (state == GAP),
    .hit     (tmr_hit)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      RN_OUT  <= '0;
      pend    <= '1;
      BUSY    <= 1'b1;
      DONE    <= 1'b0;
      REQ_ERR <= 1'b0;
      state   <= HOLD;
    end else begin
      DONE    <= 1'b0;
      REQ_ERR <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            RN_OUT <= RN_OUT & ~MASK;
            pend   <= MASK;
            BUSY   <= 1'b1;
            state  <= HOLD;
          end
        end
        HOLD, GAP: begin
          REQ_ERR <= REQ;
          if (tmr_hit) begin
            RN_OUT <= RN_OUT | rel_onehot;
            pend   <= pend_next;
            if (pend_next == '0) begin
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= GAP;
            end
          end
        end
        default: begin
          // Unreachable encoding: park safely in IDLE.
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rn_bank_release_seq.sv
// Directed bench: 4-bank default instance plus a 1-bank minimum-timing instance.
module tb_rn_bank_release_seq;

  logic       clk = 1'b0;
  logic       rst_a, req_a;
  logic [3:0] mask_a, rn_a;
  logic       busy_a, done_a, err_a;
  logic       rst_b, req_b;
  logic [0:0] mask_b, rn_b;
  logic       busy_b, done_b, err_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rn_bank_release_seq #(.N_BANKS(4), .HOLD_CYCLES(4), .GAP_CYCLES(2)) dut_a (
    .CLK(clk), .RST(rst_a), .REQ(req_a), .MASK(mask_a),
    .RN_OUT(rn_a), .BUSY(busy_a), .DONE(done_a), .REQ_ERR(err_a)
  );

  rn_bank_release_seq #(.N_BANKS(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut_b (
    .CLK(clk), .RST(rst_b), .REQ(req_b), .MASK(mask_b),
    .RN_OUT(rn_b), .BUSY(busy_b), .DONE(done_b), .REQ_ERR(err_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] rn, input logic busy,
                       input logic done, input logic err);
    chk({tag, ".rn"},   32'(rn_a),   32'(rn));
    chk({tag, ".busy"}, 32'(busy_a), 32'(busy));
    chk({tag, ".done"}, 32'(done_a), 32'(done));
    chk({tag, ".err"},  32'(err_a),  32'(err));
  endtask

  initial begin
    rst_a = 1'b1; req_a = 1'b0; mask_a = 4'b0000;
    rst_b = 1'b1; req_b = 1'b0; mask_b = 1'b0;

    // Power-on: reset sampled at edge k
    tick();
    chk_a("por.k", 4'b0000, 1, 0, 0);
    chk("por_b.k.rn", 32'(rn_b), 0);
    chk("por_b.k.busy", 32'(busy_b), 1);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    chk_a("por.k1", 4'b0000, 1, 0, 0);
    chk("por_b.k1.rn", 32'(rn_b), 1);
    chk("por_b.k1.done", 32'(done_b), 1);
    chk("por_b.k1.busy", 32'(busy_b), 0);
    tick(); tick();
    chk_a("por.k3", 4'b0000, 1, 0, 0);
    tick();
    chk_a("por.k4", 4'b0001, 1, 0, 0);
    tick();
    chk_a("por.k5", 4'b0001, 1, 0, 0);
    tick();
    chk_a("por.k6", 4'b0011, 1, 0, 0);
    tick(); tick();
    chk_a("por.k8", 4'b0111, 1, 0, 0);
    tick(); tick();
    chk_a("por.k10", 4'b1111, 0, 1, 0);
    tick();
    chk_a("por.k11", 4'b1111, 0, 0, 0);

    // Masked request at edge 0, rejection at edge 3, back-to-back at edge 7
    req_a = 1'b1; mask_a = 4'b1010;
    tick();
    chk_a("mreq.e1", 4'b0101, 1, 0, 0);
    req_a = 1'b0; mask_a = 4'b0000;
    tick(); tick();
    chk_a("mreq.e3", 4'b0101, 1, 0, 0);
    req_a = 1'b1; mask_a = 4'b0001;
    tick();
    chk_a("rej.e4", 4'b0101, 1, 0, 1);
    req_a = 1'b0; mask_a = 4'b0000;
    tick();
    chk_a("mreq.e5", 4'b0111, 1, 0, 0);
    tick();
    chk_a("mreq.e6", 4'b0111, 1, 0, 0);
    tick();
    chk_a("mreq.e7", 4'b1111, 0, 1, 0);
    req_a = 1'b1; mask_a = 4'b0100;
    tick();
    chk_a("b2b.e8", 4'b1011, 1, 0, 0);
    req_a = 1'b0; mask_a = 4'b0000;
    tick(); tick(); tick();
    chk_a("b2b.e11", 4'b1011, 1, 0, 0);
    tick();
    chk_a("b2b.e12", 4'b1111, 0, 1, 0);

    // Zero mask in IDLE is ignored silently
    req_a = 1'b1; mask_a = 4'b0000;
    tick();
    chk_a("zero.e1", 4'b1111, 0, 0, 0);
    tick();
    chk_a("zero.e2", 4'b1111, 0, 0, 0);
    req_a = 1'b0;

    // Reset mid-sequence restarts power-on schedule
    req_a = 1'b1; mask_a = 4'b1111;
    tick();
    chk_a("mid.e1", 4'b0000, 1, 0, 0);
    req_a = 1'b0; mask_a = 4'b0000;
    tick(); tick(); tick(); tick();
    chk_a("mid.e5", 4'b0001, 1, 0, 0);
    rst_a = 1'b1;
    tick();
    chk_a("mid.e6", 4'b0000, 1, 0, 0);
    rst_a = 1'b0;
    tick(); tick(); tick();
    chk_a("mid.e9", 4'b0000, 1, 0, 0);
    tick();
    chk_a("mid.e10", 4'b0001, 1, 0, 0);
    tick(); tick();
    chk_a("mid.e12", 4'b0011, 1, 0, 0);
    tick(); tick();
    chk_a("mid.e14", 4'b0111, 1, 0, 0);
    tick(); tick();
    chk_a("mid.e16", 4'b1111, 0, 1, 0);

    // Single bank, minimum timing, with a rejected request during HOLD
    req_b = 1'b1; mask_b = 1'b1;
    tick();
    chk("one.e1.rn", 32'(rn_b), 0);
    chk("one.e1.busy", 32'(busy_b), 1);
    chk("one.e1.done", 32'(done_b), 0);
    tick();
    chk("one.e2.rn", 32'(rn_b), 1);
    chk("one.e2.done", 32'(done_b), 1);
    chk("one.e2.busy", 32'(busy_b), 0);
    chk("one.e2.err", 32'(err_b), 1);
    req_b = 1'b0; mask_b = 1'b0;
    tick();
    chk("one.e3.done", 32'(done_b), 0);
    chk("one.e3.err", 32'(err_b), 0);
    chk("one.e3.rn", 32'(rn_b), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
